uart_bus_bridge: RTL and testbench
==================================

# uart_bus_bridge

Serial debug/loader bridge: receives 8N1 command frames on a UART line, decodes them, and acts as bus **initiator** on the same request/ready peripheral bus our memory-mapped peripherals respond on. Returns acknowledge or read data over its own UART transmit line. It sits beside the CPU on the system bus so a host can peek and poke memory and peripherals without firmware running.

## Interface
Parameters:
- PRESCALE, 50000000 / (9600 * 8): clock cycles per oversample tick; one bit time is 8 ticks.
- BUS_TIMEOUT, 1024: maximum cycles `o_request` is held waiting for `i_ready` before the bridge aborts.

Ports:
- i_clock  in  1  system clock; one clock domain.
- i_reset  in  1  asynchronous, active-low reset.
- o_request  out  1  bus request, held until accepted.
- o_rw  out  1  1 = write, 0 = read.
- o_address  out  32  byte address.
- o_wdata  out  32  write data.
- i_rdata  in  32  read data, valid when `i_ready` is high.
- i_ready  in  1  responder accept/complete.
- o_busy  out  1  high from the first command byte until the last reply stop bit ends.
- UART_RX  in  1  serial input; idle high; asynchronous.
- UART_TX  out  1  serial output; idle high.

## Operation
- RX front end:
  - `UART_RX` passes through a 2-flop synchronizer.
  - A tick counter wraps every PRESCALE cycles.
  - A falling edge in idle starts a frame. The start bit is re-checked 4 ticks later; if it reads high, the frame is a glitch and is dropped.
  - Data bits are then sampled every 8 ticks, LSB first, followed by the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the decoder returns to IDLE.
- Protocol, all multi-byte fields little-endian:
  - Write: 0x57 ('W'), then 4 address bytes, then 4 data bytes. Reply: 0x06.
  - Read: 0x52 ('R'), then 4 address bytes. Reply: 4 data bytes, LSB first.
  - Any other byte in IDLE: reply 0x15 (NAK), stay IDLE.
  - Bus timeout: reply 0x15 and abandon the transfer.
- Decoder states:
  - IDLE → ADDR on 'W'/'R'. The opcode is latched into `o_rw`.
  - ADDR (byte count 0..3) → DATA (write) or BUS (read) after byte 3.
  - DATA (byte count 0..3) → BUS after byte 3.
  - BUS → REPLY on `i_ready` or on timeout.
  - REPLY → IDLE after the final stop bit.
- Bytes received in BUS or REPLY are discarded; the protocol is half-duplex.
- Address and data shift registers load byte n into bits [8n+7:8n]. `o_address` and `o_wdata` update only from these registers.
- TX sends one frame per byte: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly 8×PRESCALE cycles. Reply bytes go back-to-back with no idle gap.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - `o_request`, `o_rw`, `o_busy` = 0.
  - `o_address`, `o_wdata` = 0.
  - `UART_TX` = 1.
  - State = IDLE; all counters = 0.
- Reset mid-frame or mid-transfer aborts immediately. `o_request` drops asynchronously and no reply is sent.
- Bus handshake:
  - `o_request` rises the cycle after the last command byte's stop-bit sample.
  - `o_request`, `o_rw`, `o_address`, `o_wdata` are stable while `o_request` is high.
  - The first rising edge with `i_ready` = 1 completes the transfer. `i_rdata` is captured on that edge and `o_request` is low the next cycle.
  - `i_ready` in the first request cycle is a legal 1-cycle transfer.
  - `i_ready` while `o_request` is low is ignored.
- Timeout: a counter starts at 0 when `o_request` rises. If the count reaches BUS_TIMEOUT - 1 with no `i_ready`, `o_request` drops, and a NAK is queued the next cycle.
- The first reply start bit begins on `UART_TX` the cycle after BUS exits.
- Ready and timeout in the same cycle: ready wins and the transfer completes normally.
- Width rules: tick counter is ceil(log2(PRESCALE)) bits; timeout counter is ceil(log2(BUS_TIMEOUT + 1)) bits. Both counters wrap without overflow corrupting state.

## Test plan
Benches use PRESCALE = 4 and BUS_TIMEOUT = 16. One bit = 32 cycles.
- Write: send 57 78 56 34 12 EF BE AD DE.
  - Bus sees `o_rw` = 1, `o_address` = 0x12345678, `o_wdata` = 0xDEADBEEF.
  - With `i_ready` after 3 cycles: `UART_TX` emits 0x06, start bit the cycle after acceptance.
- Read: send 52 00 10 00 00 with `i_ready` in the first request cycle and `i_rdata` = 0xCAFEF00D.
  - `o_request` is high for exactly 1 cycle.
  - TX emits 0D F0 FE CA back-to-back (40 bit times).
- Timeout: write command with `i_ready` held 0.
  - `o_request` is high for exactly 16 cycles, then TX emits 0x15.
  - A following valid read completes normally.
- Error and noise handling:
  - Unknown byte 0x41 → 0x15, decoder stays IDLE.
  - Framing error (stop bit 0) mid-address → no bus request; the next 'R' frame is decoded from scratch.
  - A 1-tick low glitch on `UART_RX` produces no byte.
- Reset: assert `i_reset` low while `o_request` is high and while TX is mid-byte.
  - Outputs reach reset values without a clock edge; `UART_TX` = 1.
  - After release, a new read command works.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// Host debug bridge: decodes 8N1 'W'/'R' command frames from UART_RX, runs the
// matching bus transfer as initiator, and answers with ACK/NAK or read data.
module uart_bus_bridge #(
    parameter int unsigned PRESCALE    = 50000000 / (9600 * 8),
    parameter int unsigned BUS_TIMEOUT = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_request,
    output logic        o_rw,
    output logic [31:0] o_address,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_ready,
    output logic        o_busy,
    input  logic        UART_RX,
    output logic        UART_TX
);
    localparam int unsigned TICK_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned TMO_W   = $clog2(BUS_TIMEOUT + 1);
    localparam int unsigned BIT_CYC = 8 * PRESCALE;
    localparam int unsigned TXC_W   = $clog2(BIT_CYC);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] BYTE_ACK = 8'h06;
    localparam logic [7:0] BYTE_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_BUS   = 3'd3,
        ST_REPLY = 3'd4
    } state_t;

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    logic              rx_meta_r, rx_sync_r, rx_prev_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s, rx_fall_s;
    logic              rx_active_r, rx_valid_r, rx_ferr_r;
    logic [3:0]        rx_bit_r;
    logic [2:0]        rx_sub_r;
    logic [7:0]        rx_shift_r;
    logic              is_op_s;

    state_t            state_r, next_state_s;
    logic [1:0]        byte_cnt_r;
    logic [31:0]       addr_sh_r, data_sh_r, addr_sh_next_s, data_sh_next_s;
    logic              rw_r, req_r, busy_r;
    logic [31:0]       address_r, wdata_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              timeout_s, req_next_s, busy_next_s;

    logic              tx_load_s;
    logic [31:0]       tx_load_buf_s;
    logic [1:0]        tx_load_left_s;
    logic              tx_line_r, tx_active_r, tx_last_s;
    logic [8:0]        tx_shift_r;
    logic [31:0]       tx_buf_r;
    logic [1:0]        tx_left_r;
    logic [3:0]        tx_idx_r;
    logic [TXC_W-1:0]  tx_cnt_r;

    assign tick_s    = (tick_cnt_r == TICK_W'(PRESCALE - 1));
    assign rx_fall_s = rx_prev_r & ~rx_sync_r;
    assign is_op_s   = (rx_shift_r == OP_WRITE) || (rx_shift_r == OP_READ);
    assign timeout_s = (tmo_cnt_r == TMO_W'(BUS_TIMEOUT - 1));
    assign tx_last_s = tx_active_r && (tx_cnt_r == TXC_W'(BIT_CYC - 1)) &&
                       (tx_idx_r == 4'd9) && (tx_left_r == 2'd0);

    // RX line synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Free-running oversample tick
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Frame receiver: bit 0 = start (checked at half bit), 1..8 data, 9 stop
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_active_r <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_ferr_r   <= 1'b0;
            rx_bit_r    <= 4'd0;
            rx_sub_r    <= 3'd0;
            rx_shift_r  <= 8'h00;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            if (!rx_active_r) begin
                if (rx_fall_s) begin
                    rx_active_r <= 1'b1;
                    rx_bit_r    <= 4'd0;
                    rx_sub_r    <= 3'd0;
                end
            end else if (tick_s) begin
                if (rx_bit_r == 4'd0) begin
                    if (rx_sub_r == 3'd3) begin
                        rx_active_r <= ~rx_sync_r;
                        rx_bit_r    <= 4'd1;
                        rx_sub_r    <= 3'd0;
                    end else begin
                        rx_sub_r <= rx_sub_r + 3'd1;
                    end
                end else if (rx_sub_r == 3'd7) begin
                    rx_sub_r <= 3'd0;
                    if (rx_bit_r == 4'd9) begin
                        rx_active_r <= 1'b0;
                        rx_valid_r  <= rx_sync_r;
                        rx_ferr_r   <= ~rx_sync_r;
                    end else begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 4'd1;
                    end
                end else begin
                    rx_sub_r <= rx_sub_r + 3'd1;
                end
            end
        end
    end

    // Decoder state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Decoder next-state logic; a framing error mid-command restarts decoding
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid_r && is_op_s) next_state_s = ST_ADDR;
                else                       next_state_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (rx_ferr_r)                              next_state_s = ST_IDLE;
                else if (rx_valid_r && byte_cnt_r == 2'd3)  next_state_s = rw_r ? ST_DATA : ST_BUS;
                else                                        next_state_s = ST_ADDR;
            end
            ST_DATA: begin
                if (rx_ferr_r)                              next_state_s = ST_IDLE;
                else if (rx_valid_r && byte_cnt_r == 2'd3)  next_state_s = ST_BUS;
                else                                        next_state_s = ST_DATA;
            end
            ST_BUS: begin
                if (i_ready || timeout_s) next_state_s = ST_REPLY;
                else                      next_state_s = ST_BUS;
            end
            ST_REPLY: begin
                if (tx_last_s) next_state_s = ST_IDLE;
                else           next_state_s = ST_REPLY;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Decoder outputs: reply selection, shift-register inputs, request and busy
    always_comb begin
        tx_load_s      = 1'b0;
        tx_load_buf_s  = 32'h0000_0000;
        tx_load_left_s = 2'd0;
        addr_sh_next_s = addr_sh_r;
        data_sh_next_s = data_sh_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid_r && !is_op_s && !tx_active_r) begin
                    tx_load_s     = 1'b1;
                    tx_load_buf_s = {24'h00_0000, BYTE_NAK};
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            ST_ADDR: begin
                if (rx_valid_r) addr_sh_next_s = put_byte(addr_sh_r, byte_cnt_r, rx_shift_r);
                else            addr_sh_next_s = addr_sh_r;
            end
            ST_DATA: begin
                if (rx_valid_r) data_sh_next_s = put_byte(data_sh_r, byte_cnt_r, rx_shift_r);
                else            data_sh_next_s = data_sh_r;
            end
            ST_BUS: begin
                // ready has priority over a simultaneous timeout
                if (i_ready) begin
                    tx_load_s = 1'b1;
                    if (rw_r) begin
                        tx_load_buf_s  = {24'h00_0000, BYTE_ACK};
                        tx_load_left_s = 2'd0;
                    end else begin
                        tx_load_buf_s  = i_rdata;
                        tx_load_left_s = 2'd3;
                    end
                end else if (timeout_s) begin
                    tx_load_s     = 1'b1;
                    tx_load_buf_s = {24'h00_0000, BYTE_NAK};
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            default: tx_load_s = 1'b0;
        endcase
        req_next_s  = (next_state_s == ST_BUS);
        busy_next_s = (next_state_s != ST_IDLE) || tx_load_s || (tx_active_r && !tx_last_s);
    end

    // Command datapath: byte counter, field shift registers, bus outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt_r <= 2'd0;
            addr_sh_r  <= 32'h0000_0000;
            data_sh_r  <= 32'h0000_0000;
            rw_r       <= 1'b0;
            address_r  <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            tmo_cnt_r  <= {TMO_W{1'b0}};
            req_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            addr_sh_r <= addr_sh_next_s;
            data_sh_r <= data_sh_next_s;
            req_r     <= req_next_s;
            busy_r    <= busy_next_s;
            if (state_r == ST_IDLE) begin
                byte_cnt_r <= 2'd0;
                if (rx_valid_r && is_op_s) rw_r <= (rx_shift_r == OP_WRITE);
            end else if (rx_valid_r && (state_r == ST_ADDR || state_r == ST_DATA)) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end
            if (next_state_s == ST_BUS && state_r != ST_BUS) begin
                address_r <= addr_sh_next_s;
                if (rw_r) wdata_r <= data_sh_next_s;
            end
            if (state_r == ST_BUS) tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            else                   tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Reply transmitter: frames stay back-to-back while bytes remain in tx_buf_r
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_line_r   <= 1'b1;
            tx_active_r <= 1'b0;
            tx_shift_r  <= 9'h1FF;
            tx_buf_r    <= 32'h0000_0000;
            tx_left_r   <= 2'd0;
            tx_idx_r    <= 4'd0;
            tx_cnt_r    <= {TXC_W{1'b0}};
        end else if (tx_load_s) begin
            tx_line_r   <= 1'b0;
            tx_active_r <= 1'b1;
            tx_shift_r  <= {1'b1, tx_load_buf_s[7:0]};
            tx_buf_r    <= {8'h00, tx_load_buf_s[31:8]};
            tx_left_r   <= tx_load_left_s;
            tx_idx_r    <= 4'd0;
            tx_cnt_r    <= {TXC_W{1'b0}};
        end else if (tx_active_r) begin
            if (tx_cnt_r == TXC_W'(BIT_CYC - 1)) begin
                tx_cnt_r <= {TXC_W{1'b0}};
                if (tx_idx_r == 4'd9) begin
                    if (tx_left_r != 2'd0) begin
                        tx_line_r  <= 1'b0;
                        tx_shift_r <= {1'b1, tx_buf_r[7:0]};
                        tx_buf_r   <= {8'h00, tx_buf_r[31:8]};
                        tx_left_r  <= tx_left_r - 2'd1;
                        tx_idx_r   <= 4'd0;
                    end else begin
                        tx_active_r <= 1'b0;
                        tx_line_r   <= 1'b1;
                    end
                end else begin
                    tx_line_r  <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                    tx_idx_r   <= tx_idx_r + 4'd1;
                end
            end else begin
                tx_cnt_r <= tx_cnt_r + TXC_W'(1);
            end
        end
    end

    assign o_request = req_r;
    assign o_rw      = rw_r;
    assign o_address = address_r;
    assign o_wdata   = wdata_r;
    assign o_busy    = busy_r;
    assign UART_TX   = tx_line_r;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized scoreboard bench for uart_bus_bridge (PRESCALE=4, BUS_TIMEOUT=16,
// one bit = 32 cycles): stimulus pushes expectations, monitors pop and compare.
module tb_uart_bus_bridge;
    localparam int BIT = 32;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic [7:0] b;
        int         kind;   // 0 free timing, 1 starts as request drops, 2 back-to-back
    } tx_exp_t;

    logic        clk, rst_n;
    logic        o_request, o_rw, o_busy, uart_rx, uart_tx, i_ready;
    logic [31:0] o_address, o_wdata, i_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bus_exp_t bus_q[$];
    tx_exp_t  tx_q[$];

    int          rsp_delay = -1;
    logic [31:0] rsp_data  = 32'h0;

    bit          tx_in = 1'b0, req_in = 1'b0, cur_valid = 1'b0, stable = 1'b1;
    int          tx_ph = 0, tx_start_c = 0, tx_prev_start = 0, req_len = 0, req_fall_c = -1;
    logic [7:0]  tx_got;
    logic [64:0] snap;
    bus_exp_t    cur;

    uart_bus_bridge #(.PRESCALE(4), .BUS_TIMEOUT(16)) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .o_request(o_request),
        .o_rw     (o_rw),
        .o_address(o_address),
        .o_wdata  (o_wdata),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .o_busy   (o_busy),
        .UART_RX  (uart_rx),
        .UART_TX  (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Responder: acknowledges a request after rsp_delay cycles (never if negative)
    initial begin
        forever begin
            @(negedge clk);
            if (o_request === 1'b1 && rsp_delay >= 0) begin
                repeat (rsp_delay) @(negedge clk);
                i_ready = 1'b1;
                i_rdata = rsp_data;
                @(negedge clk);
                i_ready = 1'b0;
                i_rdata = $urandom;
            end
        end
    end

    // Bus monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_in = 1'b0;
            end else if (o_request && !req_in) begin
                req_in  = 1'b1;
                req_len = 1;
                stable  = 1'b1;
                snap    = {o_rw, o_address, o_wdata};
                if (bus_q.size() == 0) begin
                    cur_valid = 1'b0;
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_unexpected actual=request addr %0h expected=none", o_address);
                end else begin
                    cur = bus_q.pop_front();
                    cur_valid = 1'b1;
                    check("bus_rw", o_rw, cur.rw);
                    check("bus_addr", o_address, cur.addr);
                    if (cur.rw) check("bus_wdata", o_wdata, cur.wdata);
                end
            end else if (o_request && req_in) begin
                req_len++;
                if ({o_rw, o_address, o_wdata} !== snap) stable = 1'b0;
            end else if (!o_request && req_in) begin
                req_in     = 1'b0;
                req_fall_c = cyc;
                if (cur_valid) begin
                    check("req_cycles", req_len, cur.len);
                    check("req_stable", stable, 1'b1);
                end
            end
        end
    end

    // UART TX monitor: samples the middle of each bit
    initial begin
        tx_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_in = 1'b0;
            end else if (!tx_in) begin
                if (uart_tx === 1'b0) begin
                    tx_in      = 1'b1;
                    tx_ph      = 0;
                    tx_start_c = cyc;
                end
            end else begin
                tx_ph++;
                if (tx_ph % BIT == BIT / 2) begin
                    if (tx_ph / BIT == 0) begin
                        check("tx_start_bit", uart_tx, 1'b0);
                    end else if (tx_ph / BIT <= 8) begin
                        tx_got[tx_ph / BIT - 1] = uart_tx;
                    end else begin
                        check("tx_stop_bit", uart_tx, 1'b1);
                        tx_in = 1'b0;
                        if (tx_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL tx_unexpected actual=%0h expected=none", tx_got);
                        end else begin
                            e = tx_q.pop_front();
                            check("tx_byte", tx_got, e.b);
                            if (e.kind == 1)      check("tx_latency", tx_start_c, req_fall_c);
                            else if (e.kind == 2) check("tx_back_to_back", tx_start_c - tx_prev_start, 10 * BIT);
                        end
                        tx_prev_start = tx_start_c;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || bus_q.size() != 0 || o_busy || tx_in || req_in) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 6000), 1'b1);
        repeat (40) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input bit with_data);
        send_byte(op, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'((addr >> (8 * i)) & 32'hFF), 1'b1);
        if (with_data)
            for (int i = 0; i < 4; i++) send_byte(8'((data >> (8 * i)) & 32'hFF), 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int delay);
        bus_exp_t be;
        tx_exp_t  te;
        be.rw = 1'b1; be.addr = addr; be.wdata = data;
        be.len = (delay < 0) ? 16 : delay + 1;
        bus_q.push_back(be);
        te.b = (delay < 0) ? 8'h15 : 8'h06;
        te.kind = (delay < 0) ? 0 : 1;
        tx_q.push_back(te);
        rsp_delay = delay;
        rsp_data  = $urandom;
        send_cmd(8'h57, addr, data, 1'b1);
        wait_drain("write_done");
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata, input int delay);
        bus_exp_t be;
        tx_exp_t  te;
        be.rw = 1'b0; be.addr = addr; be.wdata = 32'h0;
        be.len = (delay < 0) ? 16 : delay + 1;
        bus_q.push_back(be);
        if (delay < 0) begin
            te.b = 8'h15; te.kind = 0;
            tx_q.push_back(te);
        end else begin
            for (int i = 0; i < 4; i++) begin
                te.b = 8'((rdata >> (8 * i)) & 32'hFF);
                te.kind = (i == 0) ? 1 : 2;
                tx_q.push_back(te);
            end
        end
        rsp_delay = delay;
        rsp_data  = rdata;
        send_cmd(8'h52, addr, 32'h0, 1'b0);
        wait_drain("read_done");
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_request"}, o_request, 1'b0);
        check({tag, "_rw"}, o_rw, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_address"}, o_address, 32'h0);
        check({tag, "_wdata"}, o_wdata, 32'h0);
        check({tag, "_uart_tx"}, uart_tx, 1'b1);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_values(tag);
        bus_q.delete();
        tx_q.delete();
        rsp_delay = -1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog actual=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tx_exp_t te;
        int n;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        i_ready = 1'b0;
        i_rdata = 32'h0;
        repeat (3) @(negedge clk);
        reset_values("por");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        do_write(32'h1234_5678, 32'hDEAD_BEEF, 3);
        do_read(32'h0000_1000, 32'hCAFE_F00D, 0);

        do_write($urandom, $urandom, -1);
        do_read($urandom, $urandom, 2);

        // unknown opcode gets a NAK and leaves the decoder idle
        te.b = 8'h15; te.kind = 0;
        tx_q.push_back(te);
        send_byte(8'h41, 1'b1);
        wait_drain("nak_done");
        do_read($urandom, $urandom, 1);

        // framing error in the address phase abandons the command
        send_byte(8'h52, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        uart_rx = 1'b1;
        repeat (64) @(negedge clk);
        check("ferr_idle", o_busy, 1'b0);
        do_read($urandom, $urandom, 4);

        // one-tick glitch and a stray ready while idle
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_idle", o_busy, 1'b0);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        repeat (50) @(negedge clk);
        check("stray_ready_busy", o_busy, 1'b0);

        // reset while the request is outstanding
        begin
            bus_exp_t be;
            be.rw = 1'b1; be.addr = 32'hA5A5_0004; be.wdata = 32'h0BAD_CAFE; be.len = 16;
            bus_q.push_back(be);
            rsp_delay = -1;
            send_cmd(8'h57, be.addr, be.wdata, 1'b1);
            n = 0;
            while (!o_request && n < 100) begin @(negedge clk); n++; end
            check("pre_reset_request", o_request, 1'b1);
            reset_pulse("rst_req");
        end

        // reset while a reply byte is on the line
        send_byte(8'h41, 1'b1);
        n = 0;
        while (uart_tx && n < 400) begin @(negedge clk); n++; end
        check("pre_reset_tx_low", uart_tx, 1'b0);
        repeat (100) @(negedge clk);
        reset_pulse("rst_tx");
        repeat (400) @(negedge clk);
        do_read(32'h0000_2000, $urandom, 0);

        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) do_write($urandom, $urandom, $urandom_range(0, 6));
            else                           do_read($urandom, $urandom, $urandom_range(0, 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
